// File: rtl/niosii_multi_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : niosii_multi_timer_if
// Purpose  : Avalon-MM slave bus bundle for the multi-channel interval timer.
// Revision : 1.0 - initial release
// ============================================================================
interface niosii_multi_timer_if;
    logic        chipselect;
    logic        write_n;
    logic [4:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect, write_n, address, writedata,
        input  readdata
    );

    modport slave (
        input  chipselect, write_n, address, writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/niosii_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : niosii_multi_timer
// Purpose  : NUM_CH prescaled down-counters with snapshot, one-shot/continuous
//            modes and a shared level interrupt on an Avalon-MM slave.
// Revision : 1.0 - initial release
// ============================================================================
module niosii_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 199999
) (
    input  wire                  clk,
    input  wire                  reset_n,
    niosii_multi_timer_if.slave  bus,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] c_reset_cnt = CNT_W'(RESET_PERIOD);
    localparam logic [2:0]       c_global_ch = 3'd7;

    logic [2:0]       w_ch;
    logic [1:0]       w_reg;
    logic             w_wr;
    logic [7:0]       w_pend;
    logic [7:0][31:0] w_ch_rd;
    logic [31:0]      w_rdata;
    logic [31:0]      r_readdata;
    logic             w_unused_ok;

    assign w_ch        = bus.address[4:2];
    assign w_reg       = bus.address[1:0];
    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_unused_ok = ^bus.writedata;

    // Slots 0..7 always exist so the read mux indexes with the full 3-bit field.
    generate
        for (genvar i = 0; i < 8; i++) begin : g_ch
            if (i < NUM_CH) begin : g_live
                logic             r_to, r_run, r_ito, r_cont, r_load;
                logic [7:0]       r_presc, r_p;
                logic [CNT_W-1:0] r_period, r_cnt, r_snap;
                logic             w_sel, w_wr_ctrl, w_start, w_stop, w_tick, w_timeout;
                logic [31:0]      w_rd;

                assign w_sel     = w_wr && (w_ch == 3'(i));
                assign w_wr_ctrl = w_sel && (w_reg == 2'd1);
                assign w_start   = w_wr_ctrl && bus.writedata[2];
                assign w_stop    = w_wr_ctrl && bus.writedata[3] && !bus.writedata[2];
                assign w_tick    = r_run && (r_p == r_presc);
                assign w_timeout = w_tick && (r_cnt == '0) && !r_load;

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_to     <= 1'b0;
                        r_run    <= 1'b0;
                        r_ito    <= 1'b0;
                        r_cont   <= 1'b0;
                        r_load   <= 1'b0;
                        r_presc  <= 8'd0;
                        r_p      <= 8'd0;
                        r_period <= c_reset_cnt;
                        r_cnt    <= c_reset_cnt;
                        r_snap   <= '0;
                    end else begin
                        // A timeout on the same edge as a STATUS write must not be lost.
                        if (w_sel && (w_reg == 2'd0)) r_to <= 1'b0;
                        if (w_timeout)                r_to <= 1'b1;
                        if (w_wr_ctrl) begin
                            r_ito   <= bus.writedata[0];
                            r_cont  <= bus.writedata[1];
                            r_presc <= bus.writedata[15:8];
                        end
                        if (w_sel && (w_reg == 2'd3)) r_snap <= r_cnt;
                        if (w_sel && (w_reg == 2'd2)) r_period <= bus.writedata[CNT_W-1:0];
                        r_load <= w_sel && (w_reg == 2'd2);

                        // The cycle after a PERIOD write reloads the counter and parks the
                        // channel; only a START landing in that very cycle restarts it.
                        if (r_load) begin
                            r_cnt <= r_period;
                            r_p   <= 8'd0;
                            r_run <= w_start;
                        end else begin
                            if (w_tick) begin
                                r_p <= 8'd0;
                                if (r_cnt != '0) begin
                                    r_cnt <= r_cnt - CNT_W'(1);
                                end else begin
                                    r_cnt <= r_period;
                                    if (!r_cont) r_run <= 1'b0;
                                end
                            end else if (r_run) begin
                                r_p <= r_p + 8'd1;
                            end
                            if (w_start) begin
                                r_run <= 1'b1;
                                r_p   <= 8'd0;
                            end else if (w_stop) begin
                                r_run <= 1'b0;
                            end
                        end
                    end
                end

                always_comb begin
                    w_rd = 32'd0;
                    case (w_reg)
                        2'd0:    w_rd = {30'd0, r_run, r_to};
                        2'd1:    w_rd = {16'd0, r_presc, 6'd0, r_cont, r_ito};
                        2'd2:    w_rd = 32'(r_period);
                        default: w_rd = 32'(r_snap);
                    endcase
                end

                assign w_ch_rd[i] = w_rd;
                assign w_pend[i]  = r_to & r_ito;
            end else begin : g_none
                assign w_ch_rd[i] = 32'd0;
                assign w_pend[i]  = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        w_rdata = 32'd0;
        if (w_ch == c_global_ch) begin
            if (w_reg == 2'd0)      w_rdata = {24'd0, w_pend};
            else if (w_reg == 2'd1) w_rdata = 32'(NUM_CH);
        end else begin
            w_rdata = w_ch_rd[w_ch];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= 32'd0;
        else          r_readdata <= w_rdata;
    end

    assign bus.readdata = r_readdata;
    assign irq          = |w_pend;

endmodule
`default_nettype wire
